// File: rtl/aes_cipher_core.sv
// aes_cipher_core -- iterative AES-128/192/256 block cipher, one round per clock.
//
// Parameters:
//   NK : key length in 32-bit words (4, 6 or 8); NR = NK+6 rounds (derived).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   input block handshake; decrypt sampled on acceptance
//   data_in          input block, byte 0 at [127:120], column-major
//   w                expanded key, round key i at w[128*(NR+1)-1-128*i -: 128]
//   out_valid/ready  result handshake; data_out held until taken
//   data_out         result block
//   busy             high while a block is in ROUND or DONE
// Build option:
//   AES_BACK_TO_BACK_EN  accept a new block on the same edge the result is taken.

module aes_sbox_lane (
    input  logic [7:0] x,
    input  logic       inv,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); naturally maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a15  = gmul(a12, a3);
        a30  = gmul(a15, a15);
        a60  = gmul(a30, a30);
        a120 = gmul(a60, a60);
        a240 = gmul(a120, a120);
        a252 = gmul(a240, a12);
        return gmul(a252, a2);
    endfunction

    logic [7:0] pre_aff;
    logic [7:0] inv_out;

    // Inverse S-box runs the inverse affine first, forward S-box runs it after,
    // so one field inverter serves both directions.
    assign pre_aff = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
    assign inv_out = ginv(pre_aff);
    assign y = inv ? inv_out
                   : (inv_out ^ {inv_out[6:0], inv_out[7]} ^ {inv_out[5:0], inv_out[7:6]}
                      ^ {inv_out[4:0], inv_out[7:5]} ^ {inv_out[3:0], inv_out[7:4]} ^ 8'h63);
endmodule

module aes_cipher_core #(
    parameter  int NK = 4,
    localparam int NR = NK + 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   decrypt,
    input  logic [127:0]           data_in,
    input  logic [128*(NR+1)-1:0]  w,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           data_out,
    output logic                   busy
);
    if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
        $error("aes_cipher_core: NK must be 4, 6 or 8");
    end

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]   fsm;
    logic         mode_q;
    logic [3:0]   rnd;
    logic [127:0] st_q;

    logic               accept, last;
    logic [NR:0][127:0] wk;
    logic [3:0]         ki;
    logic [127:0]       rkey, nxt;
    logic [15:0][7:0]   sb_in, sb_out, sh, key_b, pre, mx, post;

`ifdef AES_BACK_TO_BACK_EN
    assign in_ready = (fsm == IDLE) | ((fsm == DONE) & out_ready);
`else
    assign in_ready = (fsm == IDLE);
`endif
    assign busy   = (fsm != IDLE);
    assign accept = in_valid & in_ready;
    assign last   = (rnd == 4'(NR));

    // Round key 0 sits in the top slice of w, so key i is wk[NR-i].
    assign wk = w;
    always_comb begin
        if (fsm == ROUND) ki = mode_q ? rnd : 4'(NR) - rnd;
        else              ki = decrypt ? 4'd0 : 4'(NR);
        rkey = wk[ki];
    end

    // Byte-wise substitution commutes with the row shift, so the S-box lanes
    // sit on the raw state and the (inverse) shift follows in both modes.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int R  = i % 4;
        localparam int C  = i / 4;
        localparam int ES = 4 * ((C + R) % 4) + R;
        localparam int DS = 4 * ((C + 4 - R) % 4) + R;

        assign sb_in[i] = st_q[127-8*i -: 8];
        assign key_b[i] = rkey[127-8*i -: 8];

        aes_sbox_lane u_sbox (.x(sb_in[i]), .inv(mode_q), .y(sb_out[i]));

        assign sh[i]   = mode_q ? sb_out[DS] : sb_out[ES];
        // Decrypt adds the key before InvMixColumns, encrypt after MixColumns.
        assign pre[i]  = mode_q ? (sh[i] ^ key_b[i]) : sh[i];
        assign post[i] = last ? pre[i] : mx[i];
        assign nxt[127-8*i -: 8] = mode_q ? post[i] : (post[i] ^ key_b[i]);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant coefficient row: output row r, input row k uses entry (k-r) mod 4.
    function automatic logic [7:0] mix_coef(input logic inv, input int idx);
        case (idx)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    always_comb begin
        mx = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    mx[4*c+r] = mx[4*c+r] ^ gmul(mix_coef(mode_q, (k - r) & 3), pre[4*c+k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            mode_q    <= 1'b0;
            rnd       <= 4'd0;
            st_q      <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        mode_q <= decrypt;
                        st_q   <= data_in ^ rkey;
                        rnd    <= 4'd1;
                        fsm    <= ROUND;
                    end
                end
                ROUND: begin
                    st_q <= nxt;
                    if (last) begin
                        data_out  <= nxt;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            mode_q <= decrypt;
                            st_q   <= data_in ^ rkey;
                            rnd    <= 4'd1;
                            fsm    <= ROUND;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_cipher_core.sv
// tb_aes_cipher_core -- randomized self-checking bench for aes_cipher_core.
// Three cores (NK=4/6/8) share the stimulus inputs; each has its own key bus.
// Expected results come from a table-driven AES model built inside the bench.
// Honours AES_BACK_TO_BACK_EN for the stream and backpressure expectations.

module tb_aes_cipher_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, decrypt, out_ready;
    logic [127:0] data_in;
    logic [1407:0] w4;
    logic [1663:0] w6;
    logic [1919:0] w8;
    logic [2:0]   ir, ov, bz;
    logic [127:0] dout [3];

    aes_cipher_core #(.NK(4)) u_dut4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .decrypt(decrypt), .data_in(data_in), .w(w4), .out_valid(ov[0]), .out_ready(out_ready),
        .data_out(dout[0]), .busy(bz[0]));
    aes_cipher_core #(.NK(6)) u_dut6 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .decrypt(decrypt), .data_in(data_in), .w(w6), .out_valid(ov[1]), .out_ready(out_ready),
        .data_out(dout[1]), .busy(bz[1]));
    aes_cipher_core #(.NK(8)) u_dut8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .decrypt(decrypt), .data_in(data_in), .w(w8), .out_valid(ov[2]), .out_ready(out_ready),
        .data_out(dout[2]), .busy(bz[2]));

`ifdef AES_BACK_TO_BACK_EN
    localparam int SPACING = 11;
`else
    localparam int SPACING = 12;
`endif

    int nvec = 0;
    int nerr = 0;

    // ---------------- reference model ----------------
    logic [7:0]   sbt [256];
    logic [7:0]   isbt[256];
    logic [31:0]  W   [60];
    logic [127:0] rk  [15];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic init_tables();
        logic [7:0] cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = iv[b] ^ iv[(b+4)%8] ^ iv[(b+5)%8] ^ iv[(b+6)%8] ^ iv[(b+7)%8] ^ cst[b];
            sbt[x] = s;
            isbt[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4*(nk+7); i++) begin
            if (i < nk) W[i] = key[255-32*i -: 32];
            else begin
                t = W[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                W[i] = W[i-nk] ^ t;
            end
        end
        for (int j = 0; j <= nk + 6; j++) rk[j] = {W[4*j], W[4*j+1], W[4*j+2], W[4*j+3]};
    endtask

    function automatic logic [7:0] byt(input logic [127:0] x, input int i);
        return x[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] f_sub(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv ? isbt[byt(x, i)] : sbt[byt(x, i)];
        return y;
    endfunction

    function automatic logic [127:0] f_shift(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127-8*(4*c+r) -: 8] = byt(x, 4*((inv ? c - r + 4 : c + r) % 4) + r);
        return y;
    endfunction

    function automatic logic [127:0] f_mix(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = byt(x, 4*c); a1 = byt(x, 4*c+1); a2 = byt(x, 4*c+2); a3 = byt(x, 4*c+3);
            if (!inv) y[127-32*c -: 32] = {
                gm(2,a0) ^ gm(3,a1) ^ a2 ^ a3,       a0 ^ gm(2,a1) ^ gm(3,a2) ^ a3,
                a0 ^ a1 ^ gm(2,a2) ^ gm(3,a3),       gm(3,a0) ^ a1 ^ a2 ^ gm(2,a3)};
            else y[127-32*c -: 32] = {
                gm(14,a0) ^ gm(11,a1) ^ gm(13,a2) ^ gm(9,a3),
                gm(9,a0) ^ gm(14,a1) ^ gm(11,a2) ^ gm(13,a3),
                gm(13,a0) ^ gm(9,a1) ^ gm(14,a2) ^ gm(11,a3),
                gm(11,a0) ^ gm(13,a1) ^ gm(9,a2) ^ gm(14,a3)};
        end
        return y;
    endfunction

    task automatic aes_ref(input logic [255:0] key, input int nk, input logic dec,
                           input logic [127:0] din, output logic [127:0] res);
        int nr = nk + 6;
        logic [127:0] x;
        expand(key, nk);
        if (!dec) begin
            x = din ^ rk[0];
            for (int r = 1; r <= nr; r++) begin
                x = f_shift(f_sub(x, 1'b0), 1'b0);
                if (r < nr) x = f_mix(x, 1'b0);
                x ^= rk[r];
            end
        end else begin
            x = din ^ rk[nr];
            for (int r = nr - 1; r >= 0; r--) begin
                x = f_sub(f_shift(x, 1'b1), 1'b1) ^ rk[r];
                if (r > 0) x = f_mix(x, 1'b1);
            end
        end
        res = x;
    endtask

    // ---------------- helpers ----------------
    function automatic int nk_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 6 : 8;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_w(input int s, input logic [255:0] key);
        int nr = nk_of(s) + 6;
        expand(key, nk_of(s));
        for (int i = 0; i <= nr; i++)
            case (s)
                0:       w4[128*11-1-128*i -: 128] = rk[i];
                1:       w6[128*13-1-128*i -: 128] = rk[i];
                default: w8[128*15-1-128*i -: 128] = rk[i];
            endcase
    endtask

    task automatic drain(input int s);
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (bz[s] && n < 100) begin step(); n++; end
        out_ready = 1'b0;
        nvec++;
        if (bz[s] !== 1'b0) begin nerr++; $display("FAIL drain_to_idle core%0d busy=%b want 0", s, bz[s]); end
    endtask

    // Accepts one block, returns result and the number of edges to out_valid,
    // then takes the result.
    task automatic run_block(input int s, input logic dec, input logic [127:0] din,
                             output logic [127:0] res, output int lat);
        drain(s);
        decrypt = dec; data_in = din; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        decrypt = 1'($urandom());  // must not affect the block in flight
        data_in = rnd128();
        lat = 0;
        while (!ov[s] && lat < 100) begin step(); lat++; end
        res = dout[s];
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b0;
        data_in = '0; w4 = '0; w6 = '0; w8 = '0;
        step(); step();
        for (int s = 0; s < 3; s++) begin
            nvec++; if (ir[s] !== 1'b1) begin nerr++; $display("FAIL reset_in_ready core%0d got=%b exp=1", s, ir[s]); end
            nvec++; if (ov[s] !== 1'b0) begin nerr++; $display("FAIL reset_out_valid core%0d got=%b exp=0", s, ov[s]); end
            nvec++; if (bz[s] !== 1'b0) begin nerr++; $display("FAIL reset_busy core%0d got=%b exp=0", s, bz[s]); end
            nvec++; if (dout[s] !== 128'h0) begin nerr++; $display("FAIL reset_data_out core%0d got=%h exp=0", s, dout[s]); end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic check_block(input string nm, input int s, input logic dec,
                               input logic [255:0] key, input logic [127:0] din, input logic [127:0] exp);
        logic [127:0] res;
        int lat;
        load_w(s, key);
        run_block(s, dec, din, res, lat);
        nvec++; if (res !== exp) begin nerr++; $display("FAIL %s data got=%h exp=%h", nm, res, exp); end
        nvec++; if (lat != nk_of(s) + 6) begin nerr++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, nk_of(s) + 6); end
    endtask

    task automatic test_known_vectors();
        logic [255:0] k128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        logic [255:0] k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        logic [255:0] k256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        logic [127:0] pt = 128'h00112233445566778899aabbccddeeff;
        check_block("aes128_enc", 0, 1'b0, k128, pt, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check_block("aes128_dec", 0, 1'b1, k128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, pt);
        check_block("aes192_enc", 1, 1'b0, k192, pt, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        check_block("aes256_enc", 2, 1'b0, k256, pt, 128'h8ea2b7ca516745bfeafc49904b496089);
    endtask

    task automatic test_random();
        for (int n = 0; n < 9; n++) begin
            int s = n % 3;
            logic [255:0] key = {rnd128(), rnd128()};
            logic dec = 1'($urandom());
            logic [127:0] din = rnd128();
            logic [127:0] exp;
            aes_ref(key, nk_of(s), dec, din, exp);
            check_block("random", s, dec, key, din, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] key = {rnd128(), rnd128()};
        logic [127:0] pt1 = rnd128(), pt2 = rnd128(), e1, e2;
        int lat = 0;
        aes_ref(key, 4, 1'b0, pt1, e1);
        aes_ref(key, 4, 1'b0, pt2, e2);
        load_w(0, key);
        drain(0);
        decrypt = 1'b0; data_in = pt1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (!ov[0] && lat < 100) begin step(); lat++; end
        data_in = pt2; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            nvec++; if (ov[0] !== 1'b1) begin nerr++; $display("FAIL bp_out_valid cyc%0d got=%b exp=1", c, ov[0]); end
            nvec++; if (dout[0] !== e1) begin nerr++; $display("FAIL bp_data_hold cyc%0d got=%h exp=%h", c, dout[0], e1); end
            nvec++; if (ir[0] !== 1'b0) begin nerr++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", c, ir[0]); end
            step();
        end
        out_ready = 1'b1;
        step();
        nvec++; if (ov[0] !== 1'b0) begin nerr++; $display("FAIL bp_release out_valid got=%b exp=0", ov[0]); end
        nvec++; if (dout[0] !== e1) begin nerr++; $display("FAIL bp_release data got=%h exp=%h", dout[0], e1); end
`ifdef AES_BACK_TO_BACK_EN
        nvec++; if (bz[0] !== 1'b1) begin nerr++; $display("FAIL bp_same_edge_accept busy got=%b exp=1", bz[0]); end
`else
        nvec++; if (bz[0] !== 1'b0) begin nerr++; $display("FAIL bp_idle_after_take busy got=%b exp=0", bz[0]); end
        out_ready = 1'b0;
        step();
        nvec++; if (bz[0] !== 1'b1) begin nerr++; $display("FAIL bp_second_accept busy got=%b exp=1", bz[0]); end
`endif
        in_valid = 1'b0; out_ready = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 100) begin step(); lat++; end
        nvec++; if (dout[0] !== e2) begin nerr++; $display("FAIL bp_second_block got=%h exp=%h", dout[0], e2); end
        nvec++; if (lat != 10) begin nerr++; $display("FAIL bp_second_latency got=%0d exp=10", lat); end
        drain(0);
    endtask

    task automatic test_reset_mid_block();
        logic [255:0] key = {rnd128(), rnd128()};
        logic [127:0] pt = rnd128(), exp;
        aes_ref(key, 4, 1'b1, pt, exp);
        load_w(0, key);
        drain(0);
        decrypt = 1'b0; data_in = rnd128(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();  // round counter now at 5
        rst = 1'b1;
        #1;
        nvec++; if (ov[0] !== 1'b0) begin nerr++; $display("FAIL midrst_out_valid got=%b exp=0", ov[0]); end
        nvec++; if (ir[0] !== 1'b1) begin nerr++; $display("FAIL midrst_in_ready got=%b exp=1", ir[0]); end
        nvec++; if (dout[0] !== 128'h0) begin nerr++; $display("FAIL midrst_data_out got=%h exp=0", dout[0]); end
        nvec++; if (bz[0] !== 1'b0) begin nerr++; $display("FAIL midrst_busy got=%b exp=0", bz[0]); end
        #1 rst = 1'b0;
        check_block("after_midrst", 0, 1'b1, key, pt, exp);
    endtask

    task automatic test_back_to_back();
        logic [255:0] key = {rnd128(), rnd128()};
        logic [127:0] q[$];
        logic [127:0] e;
        int last_acc = -1;
        int n = 0;
        load_w(0, key);
        drain(0);
        out_ready = 1'b1; in_valid = 1'b1;
        data_in = rnd128(); decrypt = 1'($urandom());
        for (int cyc = 0; cyc < 6 * SPACING; cyc++) begin
            logic acc = in_valid & ir[0];
            if (ov[0] && out_ready) begin
                nvec++;
                if (q.size() == 0) begin nerr++; $display("FAIL stream_unexpected_result got=%h exp=none", dout[0]); end
                else begin
                    e = q.pop_front();
                    if (dout[0] !== e) begin nerr++; $display("FAIL stream_data got=%h exp=%h", dout[0], e); end
                end
            end
            if (acc) begin
                aes_ref(key, 4, decrypt, data_in, e);
                q.push_back(e);
                if (last_acc >= 0) begin
                    nvec++;
                    if (cyc - last_acc != SPACING) begin nerr++; $display("FAIL stream_spacing got=%0d exp=%0d", cyc - last_acc, SPACING); end
                end
                last_acc = cyc;
            end
            step();
            if (acc) begin data_in = rnd128(); decrypt = 1'($urandom()); end
        end
        in_valid = 1'b0;
        while (q.size() != 0 && n < 100) begin
            if (ov[0]) begin
                e = q.pop_front();
                nvec++;
                if (dout[0] !== e) begin nerr++; $display("FAIL stream_tail_data got=%h exp=%h", dout[0], e); end
            end
            step(); n++;
        end
        nvec++;
        if (q.size() != 0) begin nerr++; $display("FAIL stream_pending got=%0d exp=0", q.size()); end
        out_ready = 1'b0;
    endtask

    initial begin
        init_tables();
        test_reset();
        test_known_vectors();
        test_random();
        test_backpressure();
        test_reset_mid_block();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
Iterative AES block cipher core with encrypt and decrypt modes, parametrised for AES-128/192/256. Sits behind the key-expansion block and consumes its expanded round-key bus. One full round is computed per clock. Blocks enter and leave through valid/ready handshakes so the core can be stalled by upstream or downstream logic.

Parameters:
NK, 4, key length in 32-bit words. Legal values are 4, 6 and 8; any other value is an elaboration error.
NR, NK+6, number of rounds. Derived localparam, not overridable.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input block present
in_ready  out  1  core can accept a block
decrypt  in  1  mode for the accepted block: 0 = encrypt, 1 = decrypt
data_in  in  128  input block; byte 0 at [127:120], column-major state order
w  in  128*(NR+1)  expanded key; round key i at w[128*(NR+1)-1-128*i -: 128]
out_valid  out  1  result available
out_ready  in  1  downstream takes the result
data_out  out  128  result block, same byte order as data_in
busy  out  1  high in ROUND and DONE

Behaviour:
- Reset (rst high, asynchronous):
  - state=IDLE, round counter=0, data_out=0, out_valid=0, busy=0, in_ready=1.
  - Reset mid-operation discards the in-flight block; no partial result is ever presented.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: latch decrypt into mode_q, load state reg = data_in ^ key0 (encrypt) or data_in ^ keyNR (decrypt), set round=1, go to ROUND.
- ROUND, one round per cycle, r = 1..NR:
  - Encrypt: SubBytes, ShiftRows, MixColumns (skipped when r==NR), xor key r.
  - Decrypt: InvShiftRows, InvSubBytes, xor key (NR-r), InvMixColumns (skipped when r==NR).
  - r<NR: round increments.
  - r==NR: result goes to data_out, out_valid=1, go to DONE.
- DONE:
  - data_out and out_valid are held stable until out_ready is sampled high.
  - On out_valid & out_ready at an edge: out_valid=0, go to IDLE. data_out keeps its last value.
- Latency: out_valid rises on the NR-th edge after the acceptance edge (10/12/14 cycles). Minimum spacing between accepted blocks is NR+2 cycles without the optional feature.
- in_ready is 0 in ROUND and DONE. in_valid in those states is ignored and the block is not consumed.
- w is not latched. The source must hold w stable from the acceptance edge until out_valid. Changing w earlier gives an undefined result, but the FSM and handshakes must still behave correctly.
- decrypt is sampled only at acceptance. Changes mid-block have no effect.
- S-box and inverse S-box:
  - Computed as GF(2^8) multiplicative inverse (poly 0x11B, inv(0)=0) plus the affine / inverse affine transform. No 256-entry tables.
  - All 16 byte lanes are evaluated in parallel.
- InvMixColumns uses coefficients 0e/0b/0d/09. GF multiply reduces by 0x1B.
- out_valid is driven from a register, not combinationally from out_ready.

Optional Feature:
Macro: AES_BACK_TO_BACK_EN.
- Defined: in_ready = (state==IDLE) | (state==DONE & out_ready).
  - A new block may be accepted on the same edge the result is taken: the FSM goes directly DONE->ROUND.
  - Minimum block spacing becomes NR+1 cycles.
- Undefined: in_ready is high only in IDLE, exactly as described in Behaviour.

Test Plan:
- AES-128 encrypt (NK=4):
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Response: data_out=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid on the 10th edge after acceptance.
- AES-128 decrypt (NK=4): ct 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out=00112233445566778899aabbccddeeff.
- AES-192 / AES-256 encrypt (NK=6 / NK=8):
  - Key 00..17 -> dda97ca4864cdfe06eaf70a0ec0d7191.
  - Key 00..1f -> 8ea2b7ca516745bfeafc49904b496089.
  - Latency is 12 / 14 edges respectively.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid: data_out stays stable, in_ready=0, and a second in_valid is not consumed.
  - Raise out_ready: out_valid drops at the next edge, then the second block is accepted.
- Reset mid-block: assert rst at round 5. out_valid=0, in_ready=1 and data_out=0 immediately; the next block runs with full correct latency and result.
- With AES_BACK_TO_BACK_EN: keep in_valid and out_ready high continuously. Blocks are accepted every NR+1 cycles and every result is correct.
